// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner with tear-free frame snapshot,
// leading-zero blanking, dead-cycle anti-ghosting and pin polarity.
module sevenseg_scan #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [7:0]            LED,
  output logic [DIGITS-1:0]     selector,
  output logic                  frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  localparam logic [7:0] LED_OFF =
    SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF =
    SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  load_pending_q, load_pending_d;
  logic [7:0]            led_q, led_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  cnt_wrap;
  logic                  frame_end;
  logic                  load;

  logic [DIGITS-1:0]     blank;
  logic                  zero_above;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank_cur;
  logic [7:0]            dec;
  logic [7:0]            seg;
  logic                  lit;
  logic [7:0]            led_raw;
  logic [DIGITS-1:0]     onehot;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    s = 8'h00;
    unique case (n)
      4'h0: s = 8'b1111_1100;
      4'h1: s = 8'b0110_0000;
      4'h2: s = 8'b1101_1010;
      4'h3: s = 8'b1111_0010;
      4'h4: s = 8'b0110_0110;
      4'h5: s = 8'b1011_0110;
      4'h6: s = 8'b1011_1110;
      4'h7: s = 8'b1110_0000;
      4'h8: s = 8'b1111_1110;
      4'h9: s = 8'b1111_0110;
      4'hA: s = 8'b1110_1110;
      4'hB: s = 8'b0011_1110;
      4'hC: s = 8'b0001_1010;
      4'hD: s = 8'b0111_1010;
      4'hE: s = 8'b1001_1110;
      4'hF: s = 8'b1000_1110;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Slot/digit counters and frame snapshot
  always_comb begin
    cnt_wrap       = (cnt_q == CNT_MAX);
    frame_end      = cnt_wrap && (idx_q == IDX_MAX);
    load           = load_pending_q || frame_end;

    cnt_d          = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d          = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    if (load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp_in;
    end

    load_pending_d = 1'b0;
    frame_done_d   = load;
  end

  // Zero run scanned from the most significant digit downwards
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above &
        (shadow_data_q[4*i +: 4] == 4'h0);
      blank[i]   = blank_lz & zero_above & (i != 0);
    end
  end

  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_cur = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = shadow_data_q[4*i +: 4];
        dp_bit    = shadow_dp_q[i];
        blank_cur = blank[i];
      end
    end
  end

  // cnt == 0 is the dead cycle between digits
  always_comb begin
    dec     = seg7(nib);
    seg     = {blank_cur ? 7'h00 : dec[7:1], dp_bit};
    lit     = enable && (cnt_q != '0);
    led_raw = lit ? seg : 8'h00;
    led_d   = SEG_ACTIVE_LOW ? ~led_raw : led_raw;

    onehot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      onehot[i] = lit && (idx_q == IW'(i));
    end
    sel_d   = SEL_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      load_pending_q <= 1'b1;
      led_q          <= LED_OFF;
      sel_q          <= SEL_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      load_pending_q <= load_pending_d;
      led_q          <= led_d;
      sel_q          <= sel_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign LED        = led_q;
  assign selector   = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: table of digit patterns checked over whole
// frames, plus snapshot, enable and mid-scan reset sequences.
module tb_sevenseg_scan;

  typedef struct packed {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic             blz;
    logic [3:0][7:0]  led;
  } vec_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] led;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;
  logic [7:0]  led, led2;
  logic [3:0]  sel, sel2;
  logic        fd, fd2;

  int checks = 0;
  int failures = 0;

  vec_t vt[8];
  exp_t sbq[$];

  always #5 clk = ~clk;

  sevenseg_scan #(
    .DIGITS(4), .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable), .LED(led),
    .selector(sel), .frame_done(fd)
  );

  sevenseg_scan #(
    .DIGITS(4), .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable), .LED(led2),
    .selector(sel2), .frame_done(fd2)
  );

  function automatic vec_t mk(
    input logic [15:0] d, input logic [3:0] p, input logic b,
    input logic [7:0] l3, input logic [7:0] l2,
    input logic [7:0] l1, input logic [7:0] l0);
    vec_t v;
    v.data = d;
    v.dp   = p;
    v.blz  = b;
    v.led  = {l3, l2, l1, l0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic apply(input vec_t v);
    int n;
    data     = v.data;
    dp_in    = v.dp;
    blank_lz = v.blz;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd && n < 40);
    chk("sync_frame_done", {7'b0, fd}, 8'h01);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_led"}, led, 8'h00);
    chk({nm, "_sel"}, {4'b0, sel}, 8'h0F);
    chk({nm, "_fd"}, {7'b0, fd}, 8'h00);
    chk({nm, "_led_al"}, led2, 8'hFF);
  endtask

  // Frame position p=1..16 counts edges after the snapshot edge
  task automatic run_frame(input vec_t v, input int first_p,
                           input int last_p, input int off_lo,
                           input int off_hi, input int chg_p);
    exp_t e;
    logic en;
    logic [3:0] oh;
    int s, c;
    for (int p = first_p; p <= last_p; p++) begin
      en = !(p >= off_lo && p <= off_hi);
      enable = en;
      s = (p - 1) / 4;
      c = (p - 1) % 4;
      e.fd = (p == 16);
      if (c == 0 || !en) begin
        e.sel = 4'hF;
        e.led = 8'h00;
      end else begin
        oh = 4'b0001 << s;
        e.sel = ~oh;
        e.led = v.led[s];
      end
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("led_p%0d", p), led, e.led);
      chk($sformatf("sel_p%0d", p), {4'b0, sel}, {4'b0, e.sel});
      chk($sformatf("fd_p%0d", p), {7'b0, fd}, {7'b0, e.fd});
      chk($sformatf("led_al_p%0d", p), led2, ~e.led);
      chk($sformatf("sel_al_p%0d", p), {4'b0, sel2},
          {4'b0, e.sel});
      if (p == chg_p) data = 16'h0000;
    end
    enable = 1'b1;
  endtask

  initial begin
    vt[0] = mk(16'h12AF, 4'h0, 1'b0, 8'h60, 8'hDA, 8'hEE, 8'h8E);
    vt[1] = mk(16'h0050, 4'h8, 1'b1, 8'h01, 8'h00, 8'hB6, 8'hFC);
    vt[2] = mk(16'h0000, 4'h0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFC);
    vt[3] = mk(16'hCB98, 4'h5, 1'b1, 8'h1A, 8'h3F, 8'hF6, 8'hFF);
    vt[4] = mk(16'h0E0D, 4'h0, 1'b1, 8'h00, 8'h9E, 8'hFC, 8'h7A);
    vt[5] = mk(16'h7634, 4'hF, 1'b0, 8'hE1, 8'hBF, 8'hF3, 8'h67);
    vt[6] = mk(16'h0000, 4'h0, 1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hFC);
    vt[7] = mk(16'h0008, 4'h0, 1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hFE);

    rst_n    = 1'b0;
    enable   = 1'b1;
    data     = vt[0].data;
    dp_in    = vt[0].dp;
    blank_lz = vt[0].blz;
    repeat (3) @(negedge clk);
    reset_vals("rst");

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_fd", {7'b0, fd}, 8'h01);
    chk("first_sel", {4'b0, sel}, 8'h0F);
    chk("first_led", led, 8'h00);
    run_frame(vt[0], 2, 16, 0, 0, -1);

    for (int i = 0; i < 8; i++) begin
      apply(vt[i]);
      run_frame(vt[i], 1, 16, 0, 0, -1);
    end

    // data cleared during digit 1 slot: this frame keeps 12AF
    apply(vt[0]);
    run_frame(vt[0], 1, 16, 0, 0, 6);
    run_frame(vt[6], 1, 16, 0, 0, -1);

    apply(vt[3]);
    run_frame(vt[3], 1, 16, 3, 12, -1);

    apply(vt[5]);
    run_frame(vt[5], 1, 10, 0, 0, -1);
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    data     = vt[1].data;
    dp_in    = vt[1].dp;
    blank_lz = vt[1].blz;
    repeat (2) @(negedge clk);
    reset_vals("midrst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_fd", {7'b0, fd}, 8'h01);
    chk("restart_sel", {4'b0, sel}, 8'h0F);
    run_frame(vt[1], 2, 16, 0, 0, -1);
    run_frame(vt[1], 1, 16, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Time-multiplexed driver for a bank of DIGITS common-selected seven-segment digits. It decodes packed 4-bit hex nibbles per digit and scans the digits round-robin at a programmable refresh rate. Each frame is taken from a tear-free snapshot of the input. It supports per-digit decimal point, leading-zero blanking, an anti-ghosting dead cycle and configurable output polarity. It sits between the datapath's display/debug register and the board's segment/selector pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 1024, clocks per digit slot (>=2)
SEG_ACTIVE_LOW, 0, 1 = invert LED pins (common-anode)
SEL_ACTIVE_LOW, 1, 1 = selector active level is 0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data  in  4*DIGITS  packed nibbles, digit i = data[4i+3:4i], digit 0 rightmost
dp_in  in  DIGITS  decimal point request per digit
blank_lz  in  1  1 = blank leading zero digits
enable  in  1  0 = display dark, scanning continues
LED  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp
selector  out  DIGITS  digit select, one-hot at active level
frame_done  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset is asynchronous on rst_n low and released synchronously to clk. Reset values:
  - cnt = 0, idx = 0.
  - Shadow data and dp = 0.
  - load_pending = 1.
  - LED = all segments off (8'h00 if SEG_ACTIVE_LOW = 0, else 8'hFF).
  - selector = all inactive.
  - frame_done = 0.
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx increments.
  - idx wraps from DIGITS-1 to 0.
- Snapshot: shadow_data/shadow_dp load from data/dp_in when:
  - load_pending = 1 (first edge after reset; clears load_pending), or
  - cnt = REFRESH_DIV-1 and idx = DIGITS-1.
  - frame_done is registered high on the edge that loads the shadow, for exactly 1 cycle.
  - Input changes mid-frame never reach the outputs before the next snapshot.
- Decode, active-high logic, nibble -> LED[7:0]:
  - 0 = 11111100, 1 = 01100000, 2 = 11011010, 3 = 11110010
  - 4 = 01100110, 5 = 10110110, 6 = 10111110, 7 = 11100000
  - 8 = 11111110, 9 = 11110110, A = 11101110, b = 00111110
  - c = 00011010, d = 01111010, E = 10011110, F = 10001110
  - LED[0] is replaced by shadow_dp[idx].
- Leading-zero blanking: digit i (i > 0) is blanked when blank_lz = 1 and shadow nibbles DIGITS-1 down to i are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives segments a–g off; its dp still follows shadow_dp[i].
- Outputs are registered, 1-cycle latency from (cnt, idx).
  - LED and selector are computed from the current idx and shadow and appear on the next edge.
- Anti-ghosting: in the cycle where cnt = 0 is registered, selector is all inactive and LED is off.
  - Each slot therefore has REFRESH_DIV-1 lit cycles.
- enable = 0: selector all inactive and LED off on the next edge.
  - cnt, idx, snapshot and frame_done continue unaffected.
- Polarity is applied last:
  - LED = SEG_ACTIVE_LOW ? ~seg : seg.
  - selector active bit = SEL_ACTIVE_LOW ? 0 : 1, all others opposite.
- Reset asserted mid-scan returns to reset values immediately; the first frame after release starts at idx 0 with a fresh snapshot.
- Width rules: cnt width = clog2(REFRESH_DIV), idx width = clog2(DIGITS) (min 1). No X on outputs for any input.

Test Plan:
- Reset: hold rst_n=0 with clk running, SEL_ACTIVE_LOW=1 -> LED=8'h00, selector=4'b1111, frame_done=0; after release frame_done pulses on the first edge.
- Scan order, DIGITS=4, REFRESH_DIV=4, data=16'h12AF, dp_in=0:
  - Per slot, one dark cycle then three lit cycles.
  - Digit 0: selector=4'b1110, LED=10001110.
  - Digit 1: selector=4'b1101, LED=11101110.
  - Digit 2: selector=4'b1011, LED=11011010.
  - Digit 3: selector=4'b0111, LED=01100000.
  - Then repeats.
- Snapshot: change data to 16'h0000 during digit 1 slot -> digits 2,3 still show 2,1; new value appears only after the frame_done pulse at the frame end; frame_done period = 16 clocks.
- Blanking: data=16'h0050, blank_lz=1, dp_in=4'b1000:
  - Digit 3 LED = 00000001.
  - Digit 2 LED = 00000000.
  - Digit 1 LED = 10110110.
  - Digit 0 LED = 11111100.
  - With data=16'h0000, only digit 0 shows 11111100.
- Enable/polarity: enable=0 for 10 cycles -> selector=4'b1111, LED=0, frame_done timing unchanged; SEG_ACTIVE_LOW=1 build shows digit 8 as 8'h01.
- Mid-scan reset: assert rst_n low during digit 2 slot -> outputs return to reset values that cycle; after release scan restarts at digit 0.
